// File: rtl/mem_arbiter.sv
// Shared instruction/data memory arbiter: round-robin grant between fetch and
// data requesters, fixed-latency access sequencing, registered ack and read data.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);
  // state   | meaning
  // IDLE    | nothing in flight; arbitrate incoming requests
  // ACCESS  | latched request on the memory; down-counting the read latency
  // RESPOND | one-cycle ack to the owner; requests ignored
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;
  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       latchedWe;
  logic       lastOwnerData;
  logic       grantData;
  logic       grantFetch;

  // On a tie the requester that was not served last wins.
  assign grantData  = dm_req & (~if_req | ~lastOwnerData);
  assign grantFetch = if_req & ~grantData;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      latchedWe     <= 1'b0;
      lastOwnerData <= 1'b0;
      owner         <= OWN_NONE;
      if_ack        <= 1'b0;
      dm_ack        <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grantData | grantFetch) begin
            state     <= ACCESS;
            cnt       <= CNT_LOAD;
            mem_addr  <= grantData ? dm_addr : if_addr;
            latchedWe <= grantData & dm_we;
            mem_we    <= grantData & dm_we;
            owner     <= grantData ? OWN_DATA : OWN_FETCH;
            if (grantData) mem_wdata <= dm_wdata;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!latchedWe) begin
              if (owner == OWN_DATA) dm_rdata <= mem_rdata;
              else                   if_rdata <= mem_rdata;
            end
            lastOwnerData <= (owner == OWN_DATA);
            if_ack        <= (owner == OWN_FETCH);
            dm_ack        <= (owner == OWN_DATA);
            state         <= RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline-level reference model checked every cycle,
// a table of arbitration vectors, hand-written corner sequences and random traffic.
module tb_mem_arbiter;
  localparam int L = 2;

  logic        clock;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic        useOv = 1'b0;
  logic [31:0] ovVal = 32'h0;

  // Memory returns a per-address word that also changes every cycle, so the
  // captured value pins down exactly which cycle was sampled.
  function automatic logic [31:0] memWord(input logic [31:0] a, input int n);
    return ((a * 32'h9E3779B1) ^ 32'h5A5A_0000) + 32'(n);
  endfunction

  function automatic logic [31:0] memVal(input logic [31:0] a, input int n);
    return useOv ? ovVal : memWord(a, n);
  endfunction

  assign mem_rdata = memVal(mem_addr, cyc);

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  // Extreme-latency builds, fetch-only traffic.
  logic [1:0]  xIfReq, xIfAck, xDmAck, xMemWe, xBusy;
  logic [31:0] xIfAddr[2], xIfRdata[2], xDmRdata[2], xMemAddr[2], xMemWdata[2], xMemRdata[2];
  logic [1:0]  xOwner[2];

  for (genvar g = 0; g < 2; g++) begin : gLat
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(g == 0 ? 1 : 15)) u (
      .clock(clock), .reset(reset),
      .if_req(xIfReq[g]), .if_addr(xIfAddr[g]), .if_ack(xIfAck[g]), .if_rdata(xIfRdata[g]),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_ack(xDmAck[g]), .dm_rdata(xDmRdata[g]),
      .mem_addr(xMemAddr[g]), .mem_wdata(xMemWdata[g]), .mem_we(xMemWe[g]),
      .mem_rdata(xMemRdata[g]), .owner(xOwner[g]), .busy(xBusy[g])
    );
    assign xMemRdata[g] = memWord(xMemAddr[g], cyc);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: the last grant as (grant cycle, requester, access), from
  // which every output in every cycle follows by arithmetic on cycle numbers.
  logic        gValid, gData, gWe, lastData;
  int          gT, freeAt;
  logic [31:0] gAddr, gWdata, expMemAddr, expIf, expDm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic modelReset();
    gValid = 1'b0; gData = 1'b0; gWe = 1'b0; lastData = 1'b0;
    gT = 0; freeAt = 0; gAddr = '0; gWdata = '0;
    expMemAddr = '0; expIf = '0; expDm = '0;
  endtask

  task automatic modelGrant(input int n);
    logic pd, pf;
    if (reset || n < freeAt) return;
    pd = dm_req && (!if_req || !lastData);
    pf = if_req && !pd;
    if (!(pd || pf)) return;
    gValid = 1'b1; gT = n; gData = pd; gWe = pd && dm_we;
    gAddr = pd ? dm_addr : if_addr; gWdata = dm_wdata;
    expMemAddr = gAddr;
    freeAt = n + L + 2;
  endtask

  task automatic checkCycle(input int n);
    logic inAcc, inResp;
    inAcc  = gValid && n >= gT + 1 && n <= gT + L;
    inResp = gValid && n == gT + L + 1;
    if (inResp) begin
      lastData = gData;
      if (!gWe) begin
        if (gData) expDm = memVal(gAddr, gT + L);
        else       expIf = memVal(gAddr, gT + L);
      end
    end
    chk("busy", busy, inAcc || inResp);
    chk("owner", owner, (inAcc || inResp) ? (gData ? 2'b10 : 2'b01) : 2'b00);
    chk("if_ack", if_ack, inResp && !gData);
    chk("dm_ack", dm_ack, inResp && gData);
    chk("mem_we", mem_we, gValid && gWe && n == gT + 1);
    chk("if_rdata", if_rdata, expIf);
    chk("dm_rdata", dm_rdata, expDm);
    chk("mem_addr", mem_addr, expMemAddr);
    if (inAcc && gWe) chk("mem_wdata", mem_wdata, gWdata);
  endtask

  task automatic tick();
    @(negedge clock);
    modelGrant(cyc - 1);
    checkCycle(cyc);
  endtask

  typedef struct {
    logic        ifReq;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] ifAddr;
    logic [31:0] dmAddr;
    logic [31:0] wdata;
    logic [1:0]  first;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [1:0]  cur;
    logic [31:0] dmBefore;
    logic        ifPend, dmPend, sawAck, found;
    int          t0, ackAt, nAck, altErr, ifCnt, dmCnt, prev, lat;

    // Expected first owner follows from round-robin history starting at "fetch last".
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h0,      2'b10};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h204, 32'hA5A5_0001, 2'b10};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h208, 32'h0,      2'b10};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h20C, 32'h0,      2'b01};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h110, 32'h210, 32'hA5A5_0002, 2'b10};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h114, 32'h214, 32'h0,      2'b01};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h118, 32'h218, 32'hA5A5_0003, 2'b10};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h11C, 32'h21C, 32'h0,      2'b01};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h120, 32'h220, 32'h0,      2'b10};

    reset = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    xIfReq = 2'b00; xIfAddr[0] = '0; xIfAddr[1] = '0;
    modelReset();
    repeat (3) tick();
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    tick();

    // LATENCY=1 and LATENCY=15 builds
    for (int g = 0; g < 2; g++) begin
      lat = (g == 0) ? 1 : 15;
      xIfAddr[g] = 32'h40 + 32'(g);
      xIfReq[g] = 1'b1;
      t0 = cyc; ackAt = -1; found = 1'b0;
      for (int k = 0; k < 24 && !found; k++) begin
        tick();
        if (xIfAck[g]) begin found = 1'b1; ackAt = cyc; end
      end
      xIfReq[g] = 1'b0;
      chk($sformatf("lat%0d.ack_delay", lat), 32'(ackAt - t0), 32'(lat + 1));
      chk($sformatf("lat%0d.rdata", lat), xIfRdata[g], memWord(32'h40 + 32'(g), t0 + lat));
      tick();
      chk($sformatf("lat%0d.ack_one_cycle", lat), xIfAck[g], 1'b0);
    end

    // Arbitration table: each entry is started from IDLE.
    for (int e = 0; e < 9; e++) begin
      if_req = tbl[e].ifReq; dm_req = tbl[e].dmReq; dm_we = tbl[e].dmWe;
      if_addr = tbl[e].ifAddr; dm_addr = tbl[e].dmAddr; dm_wdata = tbl[e].wdata;
      cur = tbl[e].first;
      for (int g = 0; g < int'(tbl[e].ifReq) + int'(tbl[e].dmReq); g++) begin
        if (g > 0) begin
          tick();
          cur = (cur == 2'b01) ? 2'b10 : 2'b01;
        end
        tick();
        chk($sformatf("tbl%0d.g%0d.owner", e, g), owner, cur);
        tick();
        tick();
        chk($sformatf("tbl%0d.g%0d.ack", e, g), (cur == 2'b01) ? if_ack : dm_ack, 1'b1);
        if (cur == 2'b01) if_req = 1'b0; else dm_req = 1'b0;
      end
      tick();
    end

    // Single fetch with a fixed memory word
    useOv = 1'b1; ovVal = 32'h8C08_0004;
    if_addr = 32'h10; if_req = 1'b1;
    tick(); chk("fetch.owner1", owner, 2'b01); chk("fetch.we1", mem_we, 1'b0);
    tick(); chk("fetch.owner2", owner, 2'b01); chk("fetch.we2", mem_we, 1'b0);
    tick(); chk("fetch.ack", if_ack, 1'b1); chk("fetch.rdata", if_rdata, 32'h8C08_0004);
    chk("fetch.owner3", owner, 2'b01);
    if_req = 1'b0;
    tick(); chk("fetch.ack_off", if_ack, 1'b0); chk("fetch.owner_idle", owner, 2'b00);
    useOv = 1'b0;

    // Store leaves dm_rdata alone
    dmBefore = expDm;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
    tick(); chk("store.we1", mem_we, 1'b1); chk("store.addr", mem_addr, 32'h20);
    chk("store.wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); chk("store.we2", mem_we, 1'b0);
    tick(); chk("store.ack", dm_ack, 1'b1); chk("store.rdata_kept", dm_rdata, dmBefore);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();

    // Reset in the middle of a store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h24; dm_wdata = 32'h1234_5678;
    tick();
    tick();
    reset = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    modelReset();
    #1;
    chk("rstmid.busy", busy, 1'b0); chk("rstmid.owner", owner, 2'b00);
    chk("rstmid.mem_we", mem_we, 1'b0); chk("rstmid.mem_addr", mem_addr, 32'h0);
    chk("rstmid.mem_wdata", mem_wdata, 32'h0);
    sawAck = 1'b0;
    repeat (2) begin tick(); sawAck |= dm_ack; end
    reset = 1'b0;
    repeat (4) begin tick(); sawAck |= dm_ack; end
    chk("rstmid.no_ack", sawAck, 1'b0);
    if_addr = 32'h44; if_req = 1'b1; t0 = cyc;
    repeat (3) tick();
    chk("rstmid.fetch_ack", if_ack, 1'b1);
    chk("rstmid.fetch_rdata", if_rdata, memWord(32'h44, t0 + L));
    if_req = 1'b0;
    tick();

    // Both requesters held high: grants must alternate
    if_req = 1'b1; if_addr = 32'h1000; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    nAck = 0; altErr = 0; ifCnt = 0; dmCnt = 0; prev = 0;
    for (int c = 0; c < 200 && (if_req || dm_req); c++) begin
      tick();
      if (if_ack) begin
        ifCnt++; nAck++; if (prev == 1) altErr++; prev = 1;
        if (nAck >= 10) if_req = 1'b0; else if_addr += 32'h4;
      end
      if (dm_ack) begin
        dmCnt++; nAck++; if (prev == 2) altErr++; prev = 2;
        if (nAck >= 10) dm_req = 1'b0;
        else begin dm_addr += 32'h4; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom; end
      end
    end
    chk("alt.total", 32'(nAck), 32'd11);
    chk("alt.order_errors", 32'(altErr), 32'd0);
    chk("alt.no_starve", 32'((ifCnt >= 5) && (dmCnt >= 5)), 32'd1);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();

    // Random traffic against the model
    ifPend = 1'b0; dmPend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (ifPend && if_ack) begin if_req = 1'b0; ifPend = 1'b0; end
      else if (!ifPend && c < 560 && $urandom_range(0, 2) == 0) begin
        ifPend = 1'b1; if_req = 1'b1; if_addr = $urandom;
      end
      if (dmPend && dm_ack) begin dm_req = 1'b0; dmPend = 1'b0; dm_we = 1'b0; end
      else if (!dmPend && c < 560 && $urandom_range(0, 2) == 0) begin
        dmPend = 1'b1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end
    chk("rand.drained", 32'(ifPend || dmPend), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
